// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, flag bit indices and buffer state encoding
package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef logic [2:0] flags_t;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/alu_flag_calc.sv
// rtl/alu_flag_calc.sv - next {Z,V,N} from a departing entry and the opcode's update mask
module alu_flag_calc
  import alu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [3:0]    opcode,
  input  logic [DW-1:0] result,
  input  logic          ovfl,
  input  flags_t        flags_q,
  output flags_t        flags_d
);

  flags_t mask;
  flags_t raw;

  always_comb begin
    mask = '0;
    case (opcode)
      OP_ADD, OP_SUB:                 mask = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask[FLAG_Z] = 1'b1;
      OP_RED, OP_PADDSB:              mask = '0;
      default:                        mask = '0;
    endcase
  end

  always_comb begin
    raw         = '0;
    raw[FLAG_Z] = (result == '0);
    raw[FLAG_V] = ovfl;
    raw[FLAG_N] = result[DW-1];
  end

  // Bits outside the mask keep their committed value.
  assign flags_d = (raw & mask) | (flags_q & ~mask);

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - 2-entry in-order skid buffer with flag commit on output handshake
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_opcode,
  input  logic [DW-1:0] in_result,
  input  logic          in_ovfl,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_opcode,
  output logic [DW-1:0] out_result,
  output logic [2:0]    flags
);

  logic [1:0]    state, state_d;
  logic [3:0]    head_op, tail_op;
  logic [DW-1:0] head_res, tail_res;
  logic          head_ovfl, tail_ovfl;
  flags_t        flags_q, flags_d;

  logic in_hs, out_hs;
  logic ld_head_in, ld_head_tail, ld_tail;

  // in_ready depends only on the state register, never on out_ready.
  assign in_ready  = (state != ST_TWO);
  assign out_valid = (state == ST_ONE) || (state == ST_TWO);
  assign in_hs     = in_valid & in_ready & ~flush;
  assign out_hs    = out_valid & out_ready;

  assign out_opcode = head_op;
  assign out_result = head_res;
  assign flags      = flags_q;

  always_comb begin
    state_d      = state;
    ld_head_in   = 1'b0;
    ld_head_tail = 1'b0;
    ld_tail      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_hs) begin
          state_d    = ST_ONE;
          ld_head_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_hs && out_hs) begin
          ld_head_in = 1'b1;
        end else if (in_hs) begin
          state_d = ST_TWO;
          ld_tail = 1'b1;
        end else if (out_hs) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_hs) begin
          state_d      = ST_ONE;
          ld_head_tail = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  alu_flag_calc #(.DW(DW)) u_flag_calc (
    .opcode  (head_op),
    .result  (head_res),
    .ovfl    (head_ovfl),
    .flags_q (flags_q),
    .flags_d (flags_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      head_op   <= '0;
      head_res  <= '0;
      head_ovfl <= 1'b0;
      tail_op   <= '0;
      tail_res  <= '0;
      tail_ovfl <= 1'b0;
      flags_q   <= '0;
    end else begin
      state <= state_d;
      if (ld_head_in) begin
        head_op   <= in_opcode;
        head_res  <= in_result;
        head_ovfl <= in_ovfl;
      end else if (ld_head_tail) begin
        head_op   <= tail_op;
        head_res  <= tail_res;
        head_ovfl <= tail_ovfl;
      end
      if (ld_tail) begin
        tail_op   <= in_opcode;
        tail_res  <= in_result;
        tail_ovfl <= in_ovfl;
      end
      // Flags commit even in a flush cycle if the head departs.
      if (out_hs) begin
        flags_q <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - scoreboard bench for alu_result_stage with directed vectors
module tb_alu_result_stage;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_opcode;
  logic [DW-1:0] in_result;
  logic          in_ovfl;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_opcode;
  logic [DW-1:0] out_result;
  logic [2:0]    flags;

  logic [19:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  alu_result_stage #(.DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_result  (in_result),
    .in_ovfl    (in_ovfl),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_result (out_result),
    .flags      (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [3:0] op, input logic [15:0] res,
                     input logic ov, input logic push);
    in_valid  = v;
    in_opcode = op;
    in_result = res;
    in_ovfl   = ov;
    if (push) exp_q.push_back({op, res});
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output actual=%h expected=none", {out_opcode, out_result});
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({out_opcode, out_result} !== e) begin
          bad++;
          $display("FAIL output_order actual=%h expected=%h", {out_opcode, out_result}, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    put(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_flags", {29'd0, flags}, 32'd0);
    chk("rst_out_opcode", {28'd0, out_opcode}, 32'd0);
    chk("rst_out_result", {16'd0, out_result}, 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD zero with overflow -> Z,V set
    out_ready = 1'b1;
    put(1'b1, 4'b0000, 16'h0000, 1'b1, 1'b1);
    chk("lat_before", {31'd0, out_valid}, 32'd0);
    cyc();
    put(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0);
    chk("lat_after", {31'd0, out_valid}, 32'd1);
    cyc();
    chk("add_zero_flags", {29'd0, flags}, 32'b110);
    chk("add_zero_empty", {31'd0, out_valid}, 32'd0);

    // Backpressure fills both entries
    out_ready = 1'b0;
    put(1'b1, 4'b0000, 16'h1234, 1'b0, 1'b1);
    cyc();
    put(1'b1, 4'b0001, 16'h8001, 1'b0, 1'b1);
    chk("one_in_ready", {31'd0, in_ready}, 32'd1);
    chk("one_head", {16'd0, out_result}, 32'h1234);
    cyc();
    put(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0);
    chk("two_in_ready", {31'd0, in_ready}, 32'd0);
    chk("two_head", {16'd0, out_result}, 32'h1234);
    cyc();
    chk("two_hold", {16'd0, out_result}, 32'h1234);
    chk("two_flags_hold", {29'd0, flags}, 32'b110);
    out_ready = 1'b1;
    cyc();
    chk("drain1_flags", {29'd0, flags}, 32'b000);
    chk("drain1_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("drain2_flags", {29'd0, flags}, 32'b001);
    chk("drain2_empty", {31'd0, out_valid}, 32'd0);

    // Streaming: XOR touches only Z
    put(1'b1, 4'b0000, 16'h8000, 1'b1, 1'b1);
    cyc();
    put(1'b1, 4'b0010, 16'h0000, 1'b0, 1'b1);
    cyc();
    put(1'b1, 4'b0010, 16'h8000, 1'b1, 1'b1);
    chk("add_neg_flags", {29'd0, flags}, 32'b011);
    cyc();
    put(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0);
    chk("xor_zero_flags", {29'd0, flags}, 32'b111);
    cyc();
    chk("xor_nz_flags", {29'd0, flags}, 32'b011);

    // Non-updating opcodes then shifts
    put(1'b1, 4'b0111, 16'h0000, 1'b1, 1'b1);
    cyc();
    put(1'b1, 4'b0011, 16'h0000, 1'b0, 1'b1);
    cyc();
    put(1'b1, 4'b1010, 16'h0000, 1'b0, 1'b1);
    chk("paddsb_flags", {29'd0, flags}, 32'b011);
    cyc();
    put(1'b1, 4'b0100, 16'h0000, 1'b1, 1'b1);
    chk("red_flags", {29'd0, flags}, 32'b011);
    cyc();
    put(1'b1, 4'b0110, 16'h0001, 1'b0, 1'b1);
    chk("op1xxx_flags", {29'd0, flags}, 32'b011);
    cyc();
    put(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0);
    chk("sll_zero_flags", {29'd0, flags}, 32'b111);
    cyc();
    chk("ror_nz_flags", {29'd0, flags}, 32'b011);

    // Flush from TWO with a competing input
    out_ready = 1'b0;
    put(1'b1, 4'b0000, 16'h0000, 1'b0, 1'b1);
    cyc();
    put(1'b1, 4'b0001, 16'h0005, 1'b1, 1'b1);
    cyc();
    flush = 1'b1;
    put(1'b1, 4'b0000, 16'h7777, 1'b0, 1'b0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    flush = 1'b0;
    put(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0);
    exp_q.delete();
    chk("flush_empty", {31'd0, out_valid}, 32'd0);
    chk("flush_flags", {29'd0, flags}, 32'b011);
    chk("flush_in_ready_after", {31'd0, in_ready}, 32'd1);

    // Flush while the head departs still commits flags
    put(1'b1, 4'b0000, 16'h0000, 1'b0, 1'b1);
    cyc();
    put(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0);
    flush = 1'b1;
    out_ready = 1'b1;
    cyc();
    flush = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    chk("flush_hs_flags", {29'd0, flags}, 32'b100);
    chk("flush_hs_empty", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset while TWO
    put(1'b1, 4'b0000, 16'h4321, 1'b0, 1'b1);
    cyc();
    put(1'b1, 4'b0001, 16'h1111, 1'b0, 1'b1);
    cyc();
    put(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0);
    chk("pre_rst_two", {31'd0, in_ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_flags", {29'd0, flags}, 32'd0);
    chk("arst_out_result", {16'd0, out_result}, 32'd0);
    exp_q.delete();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Post-reset sanity: SRA zero sets Z only
    out_ready = 1'b1;
    put(1'b1, 4'b0101, 16'h0000, 1'b1, 1'b1);
    cyc();
    put(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0);
    cyc();
    chk("sra_zero_flags", {29'd0, flags}, 32'b100);
    cyc();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter DW, default 16, datapath width of result.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  ALU presents a completed result.
REQ-005 in_ready  output  1  stage can accept; registered, not combinational from out_ready.
REQ-006 in_opcode  input  4  opcode of the producing instruction.
REQ-007 in_result  input  DW  ALU sum/result (post-saturation for PADDSB).
REQ-008 in_ovfl  input  1  signed overflow of ADD/SUB from the adder.
REQ-009 flush  input  1  discard all held entries this cycle.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  downstream (EX/MEM) accepts head.
REQ-012 out_opcode  output  4  head entry opcode.
REQ-013 out_result  output  DW  head entry result.
REQ-014 flags  output  3  committed {Z,V,N}.

Function
REQ-015 Stage SHALL be a 2-entry in-order skid buffer with states EMPTY, ONE, TWO.
REQ-016 Input handshake SHALL occur when in_valid & in_ready; output handshake when out_valid & out_ready.
REQ-017 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO.
REQ-018 out_valid SHALL be 1 in ONE and TWO; out_* SHALL always present the oldest entry.
REQ-019 Transitions: EMPTY->ONE on input; ONE->TWO on input without output; ONE->EMPTY on output without input; ONE stays ONE on simultaneous input+output; TWO->ONE on output.
REQ-020 Latency SHALL be one cycle: data accepted in cycle n is visible on out_* in cycle n+1 when stage was EMPTY.
REQ-021 Held entries SHALL remain stable while out_valid & ~out_ready.
REQ-022 Flags SHALL update only on output handshake, from the departing entry, taking effect next cycle.
REQ-023 Flag rules per opcode: ADD(0000)/SUB(0001) update Z,V,N; XOR(0010), SLL(0100), SRA(0101), ROR(0110) update Z only; RED(0011), PADDSB(0111), 1xxx leave all flags unchanged.
REQ-024 Z = (result == 0); N = result[DW-1]; V = entry's ovfl bit; flags not updated keep prior value.
REQ-025 flush SHALL force state EMPTY next cycle, dropping both entries and any same-cycle input; flags SHALL still update if an output handshake occurs in the flush cycle.
REQ-026 flush SHALL dominate in_valid; in_ready is unaffected in the flush cycle itself.

Reset
REQ-027 On rst_n low, state SHALL be EMPTY immediately (asynchronous), in_ready=1 after release, out_valid=0, flags=3'b000, out_opcode=0, out_result=0.
REQ-028 Reset asserted mid-transfer SHALL discard all entries without flag update.

Structure
REQ-029 Opcode constants, flag bit indices (Z=2, V=1, N=0) and the state encoding SHALL live in shared package alu_pkg.
REQ-030 Flag computation (per-opcode mask plus Z/V/N derivation) SHALL be one sub-module, alu_flag_calc; buffer control stays in the top.

Verification
REQ-031 ADD result 16'h0000, ovfl=1, out_ready=1 -> out_valid next cycle, flags 3'b110 one cycle after output handshake.
REQ-032 Back-to-back inputs with out_ready=0 -> ONE then TWO, in_ready=0, out_result holds first value; out_ready=1 releases both in order.
REQ-033 XOR result 16'h8000 after flags=3'b111 -> flags 3'b011 (only Z cleared, V,N kept).
REQ-034 PADDSB result 16'h0000 -> flags unchanged.
REQ-035 TWO state, flush=1 with in_valid=1, out_ready=0 -> EMPTY next cycle, out_valid=0, flags unchanged.
REQ-036 rst_n low while TWO -> out_valid=0 and flags=0 asynchronously before next clk edge.
